// File: rtl/tconvert_pkg.sv
// Package for the temperature converter.
// Holds the shared widths, conversion constants and signed data types
// used by tconvert and tconvert_scale.
//   TC_W   : width of the raw sensor reading (1/16 degC per LSB)
//   TX_W   : width of the display value (0.1 degree per LSB)
//   FRAC   : fractional bits in the raw reading
//   P_W    : width of the scaled product; x18 of a 13-bit value needs TC_W+5 bits
package tconvert_pkg;

  localparam int TC_W   = 13;
  localparam int TX_W   = 18;
  localparam int FRAC   = 4;
  localparam int C_MUL  = 10;
  localparam int F_MUL  = 18;
  localparam int F_OFFS = 320;
  localparam int RND    = 8;
  localparam int P_W    = TC_W + 5;

  typedef logic signed [TC_W-1:0] tc_t;
  typedef logic signed [TX_W-1:0] tx_t;

endpackage

// File: rtl/tconvert_scale.sv
// Combinational scaler: q = round_or_floor(tc * MUL / 16), sign-extended.
// MUL is fixed at elaboration (10 or 18) and built from shifts and adds.
// Build option: TCONVERT_ROUND_EN selects round-to-nearest (ties toward
// +infinity); without it the result truncates toward -infinity.
// Ports:
//   tc : in  signed raw reading, 1/16 degC per LSB
//   q  : out signed scaled value in tenths (without any unit offset)
module tconvert_scale
  import tconvert_pkg::*;
#(
  parameter int MUL = C_MUL
) (
  input  logic signed [TC_W-1:0] tc,
  output logic signed [TX_W-1:0] q
);

  logic signed [P_W-1:0] x;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] shifted;

  // Drop FRAC fractional bits. The arithmetic shift floors, so adding
  // half an LSB first gives nearest with ties toward +infinity.
  function automatic logic signed [P_W-1:0] rnd_shift(input logic signed [P_W-1:0] p);
`ifdef TCONVERT_ROUND_EN
    logic signed [P_W-1:0] half;
    half = P_W'(RND);
    return (p + half) >>> FRAC;
`else
    return p >>> FRAC;
`endif
  endfunction

  assign x = {{(P_W-TC_W){tc[TC_W-1]}}, tc};

  generate
    if (MUL == F_MUL) begin : g_x18
      assign prod = (x <<< 4) + (x <<< 1);
    end else begin : g_x10
      assign prod = (x <<< 3) + (x <<< 1);
    end
  endgenerate

  assign shifted = rnd_shift(prod);
  assign q       = TX_W'(shifted);

endmodule

// File: rtl/tconvert.sv
// Temperature converter: raw signed Celsius reading (1/16 degC per LSB) to a
// signed display value in tenths of a degree, Celsius or Fahrenheit.
// One clock of latency; tc and c_f are sampled together each rising edge.
// Build option: TCONVERT_ROUND_EN (round-to-nearest; otherwise floor).
// Ports:
//   clk   : in  system clock, rising edge
//   rst_n : in  synchronous reset, active-low; clears tx10
//   tc    : in  signed reading, 1/16 degC per LSB
//   c_f   : in  unit select, 0 = Celsius, 1 = Fahrenheit
//   tx10  : out signed result in tenths of the selected unit (registered)
module tconvert
  import tconvert_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [TC_W-1:0] tc,
  input  logic                   c_f,
  output logic signed [TX_W-1:0] tx10
);

  localparam tx_t F_OFFS_T = tx_t'(F_OFFS);

  tx_t c_q_p0;
  tx_t f_q_p0;
  tx_t tx10_p0;
  tx_t tx10_p1;

  tconvert_scale #(.MUL(C_MUL)) u_scale_c (
    .tc (tc),
    .q  (c_q_p0)
  );

  tconvert_scale #(.MUL(F_MUL)) u_scale_f (
    .tc (tc),
    .q  (f_q_p0)
  );

  // Both scalers see the same tc, so the selected result never mixes inputs.
  assign tx10_p0 = c_f ? (f_q_p0 + F_OFFS_T) : c_q_p0;

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx10_p1 <= '0;
    end else begin
      tx10_p1 <= tx10_p0;
    end
  end

  assign tx10 = tx10_p1;

endmodule

// File: tb/tb_tconvert.sv
module tb_tconvert;

  logic               clk;
  logic               rst_n;
  logic signed [12:0] tc;
  logic               c_f;
  logic signed [17:0] tx10;

  int n_chk;
  int n_pass;

  tconvert dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc),
    .c_f   (c_f),
    .tx10  (tx10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tc_v;
    bit cf_v;
    int exp_rnd;
    int exp_trn;
    string name;
  } vec_t;

  vec_t vecs[10];

  // Reference: exact product, floor division by 16, optional half-LSB bias.
  function automatic int floor_div16(input int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic int model(input int t, input bit f);
    int p;
    p = t * (f ? 18 : 10);
`ifdef TCONVERT_ROUND_EN
    p = p + 8;
`endif
    return floor_div16(p) + (f ? 320 : 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply(input int t, input bit f);
    @(negedge clk);
    tc  = 13'(t);
    c_f = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int t;
    bit f;
    n_chk  = 0;
    n_pass = 0;

    vecs[0] = '{2809,  1'b0, 1756,  1755,  "c_2809"};
    vecs[1] = '{2809,  1'b1, 3480,  3480,  "f_2809"};
    vecs[2] = '{0,     1'b1, 320,   320,   "f_zero"};
    vecs[3] = '{0,     1'b0, 0,     0,     "c_zero"};
    vecs[4] = '{-160,  1'b0, -100,  -100,  "c_m160"};
    vecs[5] = '{-160,  1'b1, 140,   140,   "f_m160"};
    vecs[6] = '{-4096, 1'b0, -2560, -2560, "c_min"};
    vecs[7] = '{-4096, 1'b1, -4288, -4288, "f_min"};
    vecs[8] = '{4095,  1'b0, 2559,  2559,  "c_max"};
    vecs[9] = '{4095,  1'b1, 4927,  4926,  "f_max"};

    // Reset holds the output at zero regardless of inputs.
    rst_n = 1'b0;
    tc    = 13'sd2809;
    c_f   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", int'(tx10), 0);
    @(posedge clk);
    #1;
    check("reset_hold2", int'(tx10), 0);

    // Release reset with inputs already present: result appears one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    c_f   = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", int'(tx10), model(2809, 1'b0));

    // Directed table.
    foreach (vecs[i]) begin
      apply(vecs[i].tc_v, vecs[i].cf_v);
`ifdef TCONVERT_ROUND_EN
      check(vecs[i].name, int'(tx10), vecs[i].exp_rnd);
`else
      check(vecs[i].name, int'(tx10), vecs[i].exp_trn);
`endif
    end

    // Latency: output must still show the previous result before the next edge.
    apply(-160, 1'b1);
    @(negedge clk);
    tc  = 13'sd4095;
    c_f = 1'b0;
    #1;
    check("hold_until_edge", int'(tx10), model(-160, 1'b1));
    @(posedge clk);
    #1;
    check("simul_change", int'(tx10), model(4095, 1'b0));

    // Mid-stream reset clears at the next edge, then conversion resumes.
    apply(2809, 1'b0);
    check("pre_midreset", int'(tx10), model(2809, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", int'(tx10), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_midreset", int'(tx10), model(2809, 1'b0));

    // Randomized against the reference.
    for (int k = 0; k < 300; k++) begin
      t = int'($urandom_range(0, 8191)) - 4096;
      f = 1'($urandom_range(0, 1));
      apply(t, f);
      e = model(t, f);
      check($sformatf("rand_%0d_tc%0d_cf%0d", k, t, f), int'(tx10), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
